mem_bus_master: RTL and testbench

MEM_BUS_MASTER -- requirements
Module: mem_bus_master

---
 rtl/mem_bus_master_pkg.sv | 34 +++
 rtl/mem_bus_master.sv | 120 ++++++++++++
 tb/tb_mem_bus_master.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_master_pkg.sv
// ============================================================
// mem_bus_master_pkg : shared types for the memory bus master
// Rev 1.0
// ============================================================
`default_nettype none

package mem_bus_master_pkg;

  localparam int BEATS = 4;

  typedef logic [15:0] ulogic16;

  typedef enum logic {
    WRITE = 1'b0,
    READ  = 1'b1
  } pktType_t;

  // Data[0] occupies the least significant word.
  typedef struct packed {
    pktType_t                 Type;
    ulogic16                  Address;
    ulogic16 [BEATS-1:0]      Data;
  } memPkt_t;

  typedef enum logic [1:0] {
    M_IDLE = 2'd0,
    M_ADDR = 2'd1,
    M_BEAT = 2'd2,
    M_RESP = 2'd3
  } mstState_t;

endpackage

`default_nettype wire

// File: rtl/mem_bus_master.sv
// ============================================================
// mem_bus_master : packet-to-multiplexed-bus master (addr + 4 beats)
// Rev 1.0
// ============================================================
`default_nettype none

module mem_bus_master
  import mem_bus_master_pkg::*;
#(
  parameter int BEATS = mem_bus_master_pkg::BEATS
) (
  input  logic    clk,
  input  logic    resetN,
  input  logic    pktValid,
  output logic    pktReady,
  input  memPkt_t pktIn,
  output logic    AddrValid,
  output logic    rw,
  output ulogic16 AddrDataOut,
  output logic    AddrDataEn,
  input  ulogic16 AddrDataIn,
  output logic    rspValid,
  input  logic    rspReady,
  output ulogic16 rspData [BEATS],
  output logic    wrDone
);

  mstState_t   state;
  mstState_t   state_nxt;
  memPkt_t     pkt_r;
  logic [1:0]  beat_cnt;
  logic        wr_done_r;
  ulogic16     rsp_data_r [BEATS];
  logic        last_beat;
  logic        is_read;

  assign last_beat = (beat_cnt == 2'(BEATS - 1));
  assign is_read   = (pkt_r.Type == READ);

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state <= M_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pktReady    = 1'b0;
    AddrValid   = 1'b0;
    rw          = 1'b0;
    AddrDataOut = 16'h0000;
    AddrDataEn  = 1'b0;
    rspValid    = 1'b0;
    case (state)
      M_IDLE: begin
        pktReady = 1'b1;
        if (pktValid) begin
          state_nxt = M_ADDR;
        end
      end
      M_ADDR: begin
        AddrValid   = 1'b1;
        AddrDataEn  = 1'b1;
        AddrDataOut = pkt_r.Address;
        rw          = is_read;
        state_nxt   = M_BEAT;
      end
      M_BEAT: begin
        rw = is_read;
        // Read beats release the bus so the controller can drive it back.
        if (!is_read) begin
          AddrDataEn  = 1'b1;
          AddrDataOut = pkt_r.Data[beat_cnt];
        end
        if (last_beat) begin
          state_nxt = is_read ? M_RESP : M_IDLE;
        end
      end
      M_RESP: begin
        rspValid = 1'b1;
        if (rspReady) begin
          state_nxt = M_IDLE;
        end
      end
      default: state_nxt = M_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      pkt_r     <= '0;
      beat_cnt  <= 2'd0;
      wr_done_r <= 1'b0;
      for (int i = 0; i < BEATS; i++) begin
        rsp_data_r[i] <= 16'h0000;
      end
    end else begin
      wr_done_r <= (state == M_BEAT) && last_beat && !is_read;
      if ((state == M_IDLE) && pktValid) begin
        pkt_r <= pktIn;
      end
      if (state == M_ADDR) begin
        beat_cnt <= 2'd0;
      end else if (state == M_BEAT) begin
        beat_cnt <= beat_cnt + 2'd1;
      end
      if ((state == M_BEAT) && is_read) begin
        rsp_data_r[beat_cnt] <= AddrDataIn;
      end
    end
  end

  assign wrDone  = wr_done_r;
  assign rspData = rsp_data_r;

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_master.sv
// ============================================================
// tb_mem_bus_master : directed scoreboard bench for mem_bus_master
// Rev 1.0
// ============================================================
`default_nettype none

module tb_mem_bus_master;
  import mem_bus_master_pkg::*;

  logic    clk;
  logic    resetN;
  logic    pktValid;
  logic    pktReady;
  memPkt_t pktIn;
  logic    AddrValid;
  logic    rw;
  ulogic16 AddrDataOut;
  logic    AddrDataEn;
  ulogic16 AddrDataIn;
  logic    rspValid;
  logic    rspReady;
  ulogic16 rspData [4];
  logic    wrDone;

  typedef struct {
    logic    av;
    logic    rw;
    ulogic16 d;
  } bus_t;

  bus_t    bus_q[$];
  ulogic16 rsp_q[$];
  ulogic16 wd [4];
  ulogic16 rd [4];
  int      vectors;
  int      miscompares;

  mem_bus_master #(.BEATS(4)) dut (
    .clk        (clk),
    .resetN     (resetN),
    .pktValid   (pktValid),
    .pktReady   (pktReady),
    .pktIn      (pktIn),
    .AddrValid  (AddrValid),
    .rw         (rw),
    .AddrDataOut(AddrDataOut),
    .AddrDataEn (AddrDataEn),
    .AddrDataIn (AddrDataIn),
    .rspValid   (rspValid),
    .rspReady   (rspReady),
    .rspData    (rspData),
    .wrDone     (wrDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and check any bus drive against the scoreboard.
  task automatic tick();
    bus_t e;
    @(posedge clk);
    #1;
    if (AddrDataEn === 1'b1) begin
      if (bus_q.size() == 0) begin
        chk("bus_unexpected_drive", 64'(AddrDataEn), 64'd0);
      end else begin
        e = bus_q.pop_front();
        chk("bus_beat", 64'({AddrValid, rw, AddrDataOut}), 64'({e.av, e.rw, e.d}));
      end
    end else begin
      chk("addrvalid_without_drive", 64'(AddrValid), 64'd0);
    end
  endtask

  task automatic check_reset_state();
    chk("rst_pktReady",   64'(pktReady),    64'd1);
    chk("rst_AddrValid",  64'(AddrValid),   64'd0);
    chk("rst_rw",         64'(rw),          64'd0);
    chk("rst_AddrDataEn", 64'(AddrDataEn),  64'd0);
    chk("rst_AddrData",   64'(AddrDataOut), 64'd0);
    chk("rst_rspValid",   64'(rspValid),    64'd0);
    chk("rst_wrDone",     64'(wrDone),      64'd0);
    for (int i = 0; i < 4; i++) begin
      chk("rst_rspData", 64'(rspData[i]), 64'd0);
    end
  endtask

  task automatic push_write(input ulogic16 addr, input int nbeats);
    bus_q.push_back('{av: 1'b1, rw: 1'b0, d: addr});
    for (int i = 0; i < nbeats; i++) begin
      bus_q.push_back('{av: 1'b0, rw: 1'b0, d: wd[i]});
    end
  endtask

  task automatic load_pkt(input pktType_t t, input ulogic16 addr);
    pktIn.Type    = t;
    pktIn.Address = addr;
    for (int i = 0; i < 4; i++) begin
      pktIn.Data[i] = (t == WRITE) ? wd[i] : 16'h0BAD;
    end
  endtask

  task automatic do_write(input ulogic16 addr);
    load_pkt(WRITE, addr);
    push_write(addr, 4);
    pktValid = 1'b1;
    tick();
    pktValid = 1'b0;
    pktIn    = '0;
    chk("wr_pktReady_busy", 64'(pktReady), 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("wr_no_early_done", 64'(wrDone), 64'd0);
    end
    tick();
    chk("wr_done_pulse", 64'(wrDone),   64'd1);
    chk("wr_idle_ready", 64'(pktReady), 64'd1);
    tick();
    chk("wr_done_single", 64'(wrDone), 64'd0);
  endtask

  // Beats, response and handshake of a read whose address phase is in progress.
  task automatic read_tail(input int stall);
    ulogic16 exp_rsp [4];
    for (int i = 0; i < 4; i++) rsp_q.push_back(rd[i]);
    for (int i = 0; i < 4; i++) begin
      tick();
      AddrDataIn = rd[i];
      chk("rd_beat_en",    64'(AddrDataEn), 64'd0);
      chk("rd_beat_rw",    64'(rw),         64'd1);
      chk("rd_no_early_rsp", 64'(rspValid), 64'd0);
    end
    tick();
    AddrDataIn = 16'hDEAD;
    chk("rd_rspValid",  64'(rspValid), 64'd1);
    chk("rd_resp_busy", 64'(pktReady), 64'd0);
    chk("rd_resp_rw",   64'(rw),       64'd0);
    for (int i = 0; i < 4; i++) begin
      exp_rsp[i] = rsp_q.pop_front();
      chk("rd_rspData", 64'(rspData[i]), 64'(exp_rsp[i]));
    end
    for (int s = 0; s < stall; s++) begin
      tick();
      chk("stall_rspValid", 64'(rspValid), 64'd1);
      chk("stall_pktReady", 64'(pktReady), 64'd0);
      for (int i = 0; i < 4; i++) begin
        chk("stall_rspData", 64'(rspData[i]), 64'(exp_rsp[i]));
      end
    end
    rspReady = 1'b1;
    tick();
    chk("rd_release_rspValid", 64'(rspValid), 64'd0);
    chk("rd_release_pktReady", 64'(pktReady), 64'd1);
  endtask

  task automatic do_read(input ulogic16 addr, input int stall);
    load_pkt(READ, addr);
    bus_q.push_back('{av: 1'b1, rw: 1'b1, d: addr});
    rspReady = (stall == 0);
    pktValid = 1'b1;
    tick();
    pktValid = 1'b0;
    pktIn    = '0;
    read_tail(stall);
  endtask

  initial begin
    int  gap;
    logic saw_done;
    vectors     = 0;
    miscompares = 0;
    resetN      = 1'b0;
    pktValid    = 1'b0;
    pktIn       = '0;
    AddrDataIn  = 16'h0000;
    rspReady    = 1'b1;
    tick();
    tick();
    check_reset_state();
    resetN = 1'b1;
    tick();
    chk("ready_after_reset", 64'(pktReady), 64'd1);

    // Basic write, then basic read.
    wd[0] = 16'h1111; wd[1] = 16'h2222; wd[2] = 16'h3333; wd[3] = 16'h4444;
    do_write(16'h0100);
    rd[0] = 16'hAAAA; rd[1] = 16'hBBBB; rd[2] = 16'hCCCC; rd[3] = 16'hDDDD;
    do_read(16'h0200, 0);

    // Response held off for 10 cycles.
    rd[0] = 16'h1234; rd[1] = 16'h5678; rd[2] = 16'h9ABC; rd[3] = 16'hDEF0;
    do_read(16'h0300, 10);

    // Back-to-back write then read with pktValid held high.
    wd[0] = 16'h5555; wd[1] = 16'h6666; wd[2] = 16'h7777; wd[3] = 16'h8888;
    rd[0] = 16'h0F0F; rd[1] = 16'hF0F0; rd[2] = 16'h3C3C; rd[3] = 16'hC3C3;
    load_pkt(WRITE, 16'h0400);
    push_write(16'h0400, 4);
    rspReady = 1'b1;
    pktValid = 1'b1;
    tick();
    load_pkt(READ, 16'h0500);
    bus_q.push_back('{av: 1'b1, rw: 1'b1, d: 16'h0500});
    gap      = 0;
    saw_done = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (wrDone === 1'b1) saw_done = 1'b1;
      gap = t;
      if (AddrValid === 1'b1) break;
    end
    pktValid = 1'b0;
    chk("b2b_accept_gap", 64'(gap),      64'd6);
    chk("b2b_wrDone",     64'(saw_done), 64'd1);
    read_tail(0);

    // Reset during write beat 2.
    wd[0] = 16'hA0A0; wd[1] = 16'hB1B1; wd[2] = 16'hC2C2; wd[3] = 16'hD3D3;
    load_pkt(WRITE, 16'h0600);
    push_write(16'h0600, 3);
    pktValid = 1'b1;
    tick();
    pktValid = 1'b0;
    tick();
    tick();
    tick();
    resetN = 1'b0;
    tick();
    check_reset_state();
    resetN = 1'b1;
    tick();
    chk("ready_after_abort", 64'(pktReady), 64'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("abort_no_wrDone",   64'(wrDone),   64'd0);
      chk("abort_no_rspValid", 64'(rspValid), 64'd0);
    end

    chk("bus_q_drained", 64'(bus_q.size()), 64'd0);
    chk("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
